// File: rtl/fetch_pc_unit.sv
// IF-stage program counter: sequential fetch, branch redirect, miss hold with a latched pending redirect.
// Latency 1 cycle to a new PC. Optional FETCH_ALIGN_CHECK_EN forces redirect targets to INC alignment and flags misaligned ones.
module fetch_pc_unit #(
    parameter int unsigned         ADDR_W    = 32,
    parameter int unsigned         INC       = 4,
    parameter logic [ADDR_W-1:0]   RESET_VEC = '0,
    parameter int unsigned         CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hit,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] address_branch,
    input  logic              stall,
    output logic [ADDR_W-1:0] instruction_address,
    output logic [ADDR_W-1:0] address_out,
    output logic              fetch_valid,
    output logic              redirect_pending,
    output logic [CNT_W-1:0]  redirect_count,
    output logic              misalign_err
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [ADDR_W-1:0] INC_V   = ADDR_W'(INC);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] sel_tgt;
    logic [ADDR_W-1:0] tgt_use;
    logic              apply;

    assign pc_inc  = pc_q + INC_V;

    // A same-cycle PCSrc is always newer than anything latched during the miss.
    assign sel_tgt = PCSrc ? address_branch : pend_tgt_q;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

    logic tgt_mis;
    logic mis_q, mis_d;

    assign tgt_use = sel_tgt & ~ALIGN_MASK;
    assign tgt_mis = |(sel_tgt & ALIGN_MASK);
    assign mis_d   = apply & tgt_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign misalign_err = mis_q;
`else
    assign tgt_use      = sel_tgt;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        apply      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (PCSrc) begin
                    apply = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (!hit) begin
                    state_d = ST_WAIT;
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_WAIT: begin
                // The outstanding miss must complete; redirects only take effect on its hit.
                if (hit) begin
                    state_d = ST_RUN;
                    pend_d  = 1'b0;
                    if (PCSrc || pend_q) begin
                        apply = 1'b1;
                    end else if (!stall) begin
                        pc_d = pc_inc;
                    end
                end else if (PCSrc) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = address_branch;
                end
            end
            default: begin
                state_d = ST_RUN;
                pend_d  = 1'b0;
            end
        endcase

        if (apply) begin
            pc_d = tgt_use;
        end
    end

    assign cnt_d = (apply && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VEC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign instruction_address = pc_q;
    assign address_out         = pc_inc;
    // Reset gating keeps both flags low during the reset cycle itself, before the registers clear.
    assign fetch_valid         = ~reset & (state_q == ST_RUN) & hit & ~stall & ~pend_q & ~PCSrc;
    assign redirect_pending    = ~reset & pend_q;
    assign redirect_count      = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, redirects in RUN and WAIT, wrap, stall, saturation, reset mid-miss.
module tb_fetch_pc_unit;

    localparam int CNT_W = 4;

    logic        clk;
    logic        reset;
    logic        hit;
    logic        PCSrc;
    logic [31:0] address_branch;
    logic        stall;
    logic [31:0] instruction_address;
    logic [31:0] address_out;
    logic        fetch_valid;
    logic        redirect_pending;
    logic [CNT_W-1:0] redirect_count;
    logic        misalign_err;

    int n_checks;
    int n_fail;

    fetch_pc_unit #(
        .ADDR_W    (32),
        .INC       (4),
        .RESET_VEC (32'h0),
        .CNT_W     (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .hit                 (hit),
        .PCSrc               (PCSrc),
        .address_branch      (address_branch),
        .stall               (stall),
        .instruction_address (instruction_address),
        .address_out         (address_out),
        .fetch_valid         (fetch_valid),
        .redirect_pending    (redirect_pending),
        .redirect_count      (redirect_count),
        .misalign_err        (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic s, input logic p, input logic [31:0] t);
        hit = h;
        stall = s;
        PCSrc = p;
        address_branch = t;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0ABC);
        tick();
        n_checks++; if (instruction_address !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", instruction_address, 32'h0); end
        n_checks++; if (address_out !== 32'h4) begin n_fail++; $display("FAIL reset_addr_out got %h want %h", address_out, 32'h4); end
        n_checks++; if (redirect_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", redirect_count); end
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid got %b want 0", fetch_valid); end
        n_checks++; if (redirect_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", redirect_pending); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b want 0", misalign_err); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            n_checks++; if (instruction_address !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, instruction_address, 32'(i * 4)); end
            n_checks++; if (address_out !== 32'(i * 4 + 4)) begin n_fail++; $display("FAIL seq_addr_out[%0d] got %h want %h", i, address_out, 32'(i * 4 + 4)); end
            n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fetch_valid[%0d] got %b want 1", i, fetch_valid); end
            tick();
        end
    endtask

    task automatic test_redirect_run();
        drive(1'b1, 1'b0, 1'b1, 32'h100);
        n_checks++; if (instruction_address !== 32'h10) begin n_fail++; $display("FAIL run_redir_pc_before got %h want %h", instruction_address, 32'h10); end
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL run_redir_fetch_valid got %b want 0", fetch_valid); end
        tick();
        n_checks++; if (instruction_address !== 32'h100) begin n_fail++; $display("FAIL run_redir_pc got %h want %h", instruction_address, 32'h100); end
        n_checks++; if (address_out !== 32'h104) begin n_fail++; $display("FAIL run_redir_addr_out got %h want %h", address_out, 32'h104); end
        n_checks++; if (redirect_count !== 4'd1) begin n_fail++; $display("FAIL run_redir_count got %0d want 1", redirect_count); end
    endtask

    task automatic test_miss_pending();
        drive(1'b1, 1'b0, 1'b1, 32'h20);
        tick();
        n_checks++; if (instruction_address !== 32'h20) begin n_fail++; $display("FAIL miss_setup_pc got %h want %h", instruction_address, 32'h20); end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL miss_fetch_valid got %b want 0", fetch_valid); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h200);
        tick();
        n_checks++; if (instruction_address !== 32'h20) begin n_fail++; $display("FAIL miss_hold_pc got %h want %h", instruction_address, 32'h20); end
        n_checks++; if (redirect_pending !== 1'b1) begin n_fail++; $display("FAIL miss_pending_set got %b want 1", redirect_pending); end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        n_checks++; if (instruction_address !== 32'h20) begin n_fail++; $display("FAIL miss_hold_pc2 got %h want %h", instruction_address, 32'h20); end
        n_checks++; if (redirect_pending !== 1'b1) begin n_fail++; $display("FAIL miss_pending_keep got %b want 1", redirect_pending); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL miss_hit_fetch_valid got %b want 0", fetch_valid); end
        tick();
        n_checks++; if (instruction_address !== 32'h200) begin n_fail++; $display("FAIL miss_redir_pc got %h want %h", instruction_address, 32'h200); end
        n_checks++; if (redirect_pending !== 1'b0) begin n_fail++; $display("FAIL miss_pending_clear got %b want 0", redirect_pending); end
        n_checks++; if (redirect_count !== 4'd3) begin n_fail++; $display("FAIL miss_count got %0d want 3", redirect_count); end
    endtask

    task automatic test_pcsrc_hit_wait();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h300);
        tick();
        n_checks++; if (redirect_pending !== 1'b1) begin n_fail++; $display("FAIL newest_pending got %b want 1", redirect_pending); end
        drive(1'b1, 1'b0, 1'b1, 32'h400);
        tick();
        n_checks++; if (instruction_address !== 32'h400) begin n_fail++; $display("FAIL newest_pc got %h want %h", instruction_address, 32'h400); end
        n_checks++; if (redirect_count !== 4'd4) begin n_fail++; $display("FAIL newest_count got %0d want 4", redirect_count); end
        n_checks++; if (redirect_pending !== 1'b0) begin n_fail++; $display("FAIL newest_pending_clear got %b want 0", redirect_pending); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL newest_back_to_run got %b want 1", fetch_valid); end
        tick();
        n_checks++; if (instruction_address !== 32'h404) begin n_fail++; $display("FAIL newest_seq_pc got %h want %h", instruction_address, 32'h404); end
    endtask

    task automatic test_wrap_and_stall();
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (instruction_address !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got %h want %h", instruction_address, 32'hFFFF_FFFC); end
        n_checks++; if (address_out !== 32'h0) begin n_fail++; $display("FAIL wrap_addr_out got %h want %h", address_out, 32'h0); end
        n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_fetch_valid got %b want 1", fetch_valid); end
        tick();
        n_checks++; if (instruction_address !== 32'h0) begin n_fail++; $display("FAIL wrap_next_pc got %h want %h", instruction_address, 32'h0); end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_fetch_valid got %b want 0", fetch_valid); end
        tick();
        n_checks++; if (instruction_address !== 32'h0) begin n_fail++; $display("FAIL stall_hold_pc got %h want %h", instruction_address, 32'h0); end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL wait_stall_fetch_valid got %b want 0", fetch_valid); end
        tick();
        n_checks++; if (instruction_address !== 32'h0) begin n_fail++; $display("FAIL wait_stall_hold_pc got %h want %h", instruction_address, 32'h0); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL wait_stall_to_run got %b want 1", fetch_valid); end
        tick();
        n_checks++; if (instruction_address !== 32'h4) begin n_fail++; $display("FAIL wait_stall_resume_pc got %h want %h", instruction_address, 32'h4); end
        n_checks++; if (redirect_count !== 4'd5) begin n_fail++; $display("FAIL wrap_count got %0d want 5", redirect_count); end
    endtask

    task automatic test_wait_stall_redirect();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h500);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_redir_fetch_valid got %b want 0", fetch_valid); end
        tick();
        n_checks++; if (instruction_address !== 32'h500) begin n_fail++; $display("FAIL stall_redir_pc got %h want %h", instruction_address, 32'h500); end
        n_checks++; if (redirect_pending !== 1'b0) begin n_fail++; $display("FAIL stall_redir_pending got %b want 0", redirect_pending); end
        n_checks++; if (redirect_count !== 4'd6) begin n_fail++; $display("FAIL stall_redir_count got %0d want 6", redirect_count); end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic        exp_mis;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_pc  = 32'h100;
        exp_mis = 1'b1;
`else
        exp_pc  = 32'h102;
        exp_mis = 1'b0;
`endif
        drive(1'b1, 1'b0, 1'b1, 32'h102);
        tick();
        n_checks++; if (instruction_address !== exp_pc) begin n_fail++; $display("FAIL misalign_pc got %h want %h", instruction_address, exp_pc); end
        n_checks++; if (misalign_err !== exp_mis) begin n_fail++; $display("FAIL misalign_flag got %b want %b", misalign_err, exp_mis); end
        n_checks++; if (redirect_count !== 4'd7) begin n_fail++; $display("FAIL misalign_count got %0d want 7", redirect_count); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse_end got %b want 0", misalign_err); end
        n_checks++; if (instruction_address !== exp_pc + 32'h4) begin n_fail++; $display("FAIL misalign_seq_pc got %h want %h", instruction_address, exp_pc + 32'h4); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h40);
            tick();
        end
        n_checks++; if (redirect_count !== 4'd15) begin n_fail++; $display("FAIL sat_reach got %0d want 15", redirect_count); end
        drive(1'b1, 1'b0, 1'b1, 32'h80);
        tick();
        n_checks++; if (redirect_count !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", redirect_count); end
        n_checks++; if (instruction_address !== 32'h80) begin n_fail++; $display("FAIL sat_pc got %h want %h", instruction_address, 32'h80); end
    endtask

    task automatic test_reset_mid_miss();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h600);
        tick();
        n_checks++; if (redirect_pending !== 1'b1) begin n_fail++; $display("FAIL rst_miss_pending_set got %b want 1", redirect_pending); end
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (redirect_pending !== 1'b0) begin n_fail++; $display("FAIL rst_miss_pending_gate got %b want 0", redirect_pending); end
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_miss_fetch_valid got %b want 0", fetch_valid); end
        tick();
        n_checks++; if (instruction_address !== 32'h0) begin n_fail++; $display("FAIL rst_miss_pc got %h want %h", instruction_address, 32'h0); end
        n_checks++; if (redirect_count !== 4'd0) begin n_fail++; $display("FAIL rst_miss_count got %0d want 0", redirect_count); end
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rst_miss_run got %b want 1", fetch_valid); end
        n_checks++; if (redirect_pending !== 1'b0) begin n_fail++; $display("FAIL rst_miss_pending_clear got %b want 0", redirect_pending); end
        tick();
        n_checks++; if (instruction_address !== 32'h4) begin n_fail++; $display("FAIL rst_miss_seq_pc got %h want %h", instruction_address, 32'h4); end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        hit            = 1'b0;
        stall          = 1'b0;
        PCSrc          = 1'b0;
        address_branch = 32'h0;
        test_reset();
        test_sequential();
        test_redirect_run();
        test_miss_pending();
        test_pcsrc_hit_wait();
        test_wrap_and_stall();
        test_wait_stall_redirect();
        test_misalign();
        test_saturation();
        test_reset_mid_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
